// File: rtl/pkt_reader.sv
// pkt_reader: walks a packet's page chain, reads every line from the packet buffer, forwards words to tx and frees pages.
// Word format: pcc = data[PFW_SZ-1:PFW_SZ-2], any EOP code has pcc[1] set; request = {write, port[1:0], page, line, data}.
module pkt_reader #(
  parameter int PORT_ID   = 0,
  parameter int RD_DEPTH  = 4,
  parameter int LL_PG_ASZ = 4,
  parameter int PFW_SZ    = 34,
  parameter int PBR_SZ    = 3 + LL_PG_ASZ + 2 + PFW_SZ
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 f2r_srdy,
  output logic                 f2r_drdy,
  input  logic [LL_PG_ASZ-1:0] f2r_start,
  input  logic [LL_PG_ASZ-1:0] f2r_end,
  output logic                 lrq_srdy,
  input  logic                 lrq_drdy,
  output logic [LL_PG_ASZ-1:0] lrq_page,
  input  logic                 lrs_srdy,
  output logic                 lrs_drdy,
  input  logic [LL_PG_ASZ-1:0] lrs_page,
  output logic                 pbrr_srdy,
  input  logic                 pbrr_drdy,
  output logic [PBR_SZ-1:0]    pbrr_data,
  input  logic                 pbrs_srdy,
  output logic                 pbrs_drdy,
  input  logic [PFW_SZ-1:0]    pbrs_data,
  output logic                 ptx_srdy,
  input  logic                 ptx_drdy,
  output logic [PFW_SZ-1:0]    ptx_data,
  output logic                 drf_srdy,
  input  logic                 drf_drdy,
  output logic [LL_PG_ASZ-1:0] drf_page
);
  localparam int AW = $clog2(RD_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = LL_PG_ASZ + 2;
  localparam logic [CW-1:0] FULL = CW'(RD_DEPTH);
  typedef enum logic [1:0] {s_idle, s_read, s_link} state_t;
  state_t state;
  logic [LL_PG_ASZ-1:0] cur_pg, end_pg, nxt_pg;
  logic [1:0] line;
  logic link_req, link_vld, drop;
  logic [CW-1:0] credit, tag_cnt, rsp_cnt;
  logic [AW-1:0] tag_wp, tag_rp, rsp_wp, rsp_rp;
  logic [TW-1:0] tag_mem [RD_DEPTH];
  logic [PFW_SZ-1:0] rsp_mem [RD_DEPTH];
  logic [TW-1:0] head;
  logic f2r_go, pbrr_go, lrq_go, lrs_go, pbrs_go, pop, drf_ok;

  assign f2r_drdy  = state == s_idle && !reset;
  // tag occupancy also bounds issue so a stalled tx port cannot overrun either FIFO
  assign pbrr_srdy = state == s_read && credit < FULL && tag_cnt < FULL;
  assign pbrr_data = {1'b0, 2'(PORT_ID), cur_pg, line, {PFW_SZ{1'b0}}};
  assign lrq_srdy  = state != s_idle && cur_pg != end_pg && !link_req;
  assign lrq_page  = cur_pg;
  assign lrs_drdy  = state != s_idle && link_req && !link_vld;
  assign pbrs_drdy = !reset;
  assign head      = tag_mem[tag_rp];
  assign drf_ok    = !head[1] || !drf_srdy;
  assign ptx_srdy  = rsp_cnt != '0 && !drop && drf_ok;
  assign ptx_data  = rsp_mem[rsp_rp];
  assign pop       = rsp_cnt != '0 && drf_ok && (drop || ptx_drdy);
  assign f2r_go    = f2r_srdy && f2r_drdy;
  assign pbrr_go   = pbrr_srdy && pbrr_drdy;
  assign lrq_go    = lrq_srdy && lrq_drdy;
  assign lrs_go    = lrs_srdy && lrs_drdy;
  assign pbrs_go   = pbrs_srdy && pbrs_drdy;

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state    <= s_idle;
      cur_pg   <= '0;
      end_pg   <= '0;
      nxt_pg   <= '0;
      line     <= '0;
      link_req <= 1'b0;
      link_vld <= 1'b0;
    end else begin
      case (state)
        s_idle:
          if (f2r_go) begin
            cur_pg   <= f2r_start;
            end_pg   <= f2r_end;
            line     <= '0;
            link_req <= 1'b0;
            link_vld <= 1'b0;
            state    <= s_read;
          end
        s_read: begin
          if (lrq_go) link_req <= 1'b1;
          if (lrs_go) begin
            nxt_pg   <= lrs_page;
            link_vld <= 1'b1;
          end
          if (pbrr_go) begin
            line <= line + 2'd1;
            if (line == 2'd3) begin
              if (cur_pg == end_pg) state <= s_idle;
              else if (link_vld || lrs_go) begin
                cur_pg   <= link_vld ? nxt_pg : lrs_page;
                link_req <= 1'b0;
                link_vld <= 1'b0;
              end else state <= s_link;
            end
          end
        end
        s_link: begin
          if (lrq_go) link_req <= 1'b1;
          if (lrs_go) begin
            cur_pg   <= lrs_page;
            line     <= '0;
            link_req <= 1'b0;
            link_vld <= 1'b0;
            state    <= s_read;
          end
        end
        default: state <= s_idle;
      endcase
    end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      credit   <= '0;
      tag_cnt  <= '0;
      rsp_cnt  <= '0;
      tag_wp   <= '0;
      tag_rp   <= '0;
      rsp_wp   <= '0;
      rsp_rp   <= '0;
      drop     <= 1'b0;
      drf_srdy <= 1'b0;
      drf_page <= '0;
    end else begin
      credit  <= credit + CW'(pbrr_go) - CW'(pbrs_go);
      tag_cnt <= tag_cnt + CW'(pbrr_go) - CW'(pop);
      rsp_cnt <= rsp_cnt + CW'(pbrs_go) - CW'(pop);
      tag_wp  <= tag_wp + AW'(pbrr_go);
      tag_rp  <= tag_rp + AW'(pop);
      rsp_wp  <= rsp_wp + AW'(pbrs_go);
      rsp_rp  <= rsp_rp + AW'(pop);
      if (drf_srdy && drf_drdy) drf_srdy <= 1'b0;
      if (pop) begin
        drop <= drop ? !head[0] : ptx_data[PFW_SZ-1] && !head[0];
        if (head[1]) begin
          drf_srdy <= 1'b1;
          drf_page <= head[TW-1:2];
        end
      end
    end

  always_ff @(posedge clk) begin
    if (pbrr_go) tag_mem[tag_wp] <= {cur_pg, line == 2'd3, line == 2'd3 && cur_pg == end_pg};
    if (pbrs_go) rsp_mem[rsp_wp] <= pbrs_data;
  end
endmodule

// File: tb/tb_pkt_reader.sv
// tb_pkt_reader: directed packets against link-table and packet-buffer responders with hand-derived expectations.
module tb_pkt_reader;
  localparam int PG = 4;
  localparam int FW = 34;
  localparam int RD = 4;
  localparam int BW = 3 + PG + 2 + FW;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic f2r_srdy = 1'b0, f2r_drdy;
  logic [PG-1:0] f2r_start = '0, f2r_end = '0;
  logic lrq_srdy, lrq_drdy = 1'b1;
  logic [PG-1:0] lrq_page;
  logic lrs_srdy, lrs_drdy;
  logic [PG-1:0] lrs_page;
  logic pbrr_srdy, pbrr_drdy = 1'b1;
  logic [BW-1:0] pbrr_data;
  logic pbrs_srdy, pbrs_drdy;
  logic [FW-1:0] pbrs_data;
  logic ptx_srdy, ptx_drdy = 1'b1;
  logic [FW-1:0] ptx_data;
  logic drf_srdy, drf_drdy = 1'b1;
  logic [PG-1:0] drf_page;

  pkt_reader #(.PORT_ID(0), .RD_DEPTH(RD), .LL_PG_ASZ(PG), .PFW_SZ(FW)) dut (
    .clk(clk), .reset(reset),
    .f2r_srdy(f2r_srdy), .f2r_drdy(f2r_drdy), .f2r_start(f2r_start), .f2r_end(f2r_end),
    .lrq_srdy(lrq_srdy), .lrq_drdy(lrq_drdy), .lrq_page(lrq_page),
    .lrs_srdy(lrs_srdy), .lrs_drdy(lrs_drdy), .lrs_page(lrs_page),
    .pbrr_srdy(pbrr_srdy), .pbrr_drdy(pbrr_drdy), .pbrr_data(pbrr_data),
    .pbrs_srdy(pbrs_srdy), .pbrs_drdy(pbrs_drdy), .pbrs_data(pbrs_data),
    .ptx_srdy(ptx_srdy), .ptx_drdy(ptx_drdy), .ptx_data(ptx_data),
    .drf_srdy(drf_srdy), .drf_drdy(drf_drdy), .drf_page(drf_page)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;
  logic [PG+1:0] rd_log[$], pend[$];
  logic [PG-1:0] lrq_log[$], lnk_pend[$], drf_log[$];
  logic [FW-1:0] ptx_log[$];
  int rd_cyc[$];
  int cyc = 0, pbrs_hold = 0, lnk_delay = 1, lnk_wait = 0, max_out = 0, hdr_bad = 0;
  logic [PG-1:0] nxt_tbl [16];
  logic [PG-1:0] eop_pg = '0;
  logic [1:0] eop_ln = '0;
  logic prev_stall = 1'b0;
  logic [FW-1:0] prev_ptx = '0;

  function automatic logic [FW-1:0] word(logic [PG-1:0] p, logic [1:0] l);
    return {(p == eop_pg && l == eop_ln) ? 2'b10 : 2'b00, 26'h2A00000, p, l};
  endfunction

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // responders and monitors: transfers are sampled at negedge, responses driven just after posedge
  initial begin
    logic [PG+1:0] a;
    pbrs_srdy = 1'b0;
    pbrs_data = '0;
    lrs_srdy  = 1'b0;
    lrs_page  = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset) begin
        if (prev_stall) begin
          check("ptx_hold_srdy", ptx_srdy, 1);
          check("ptx_hold_data", ptx_data, prev_ptx);
        end
        prev_stall = ptx_srdy && !ptx_drdy;
        prev_ptx = ptx_data;
        if (pbrs_srdy && pbrs_drdy) void'(pend.pop_front());
        if (pbrr_srdy && pbrr_drdy) begin
          rd_log.push_back(pbrr_data[FW+PG+1:FW]);
          pend.push_back(pbrr_data[FW+PG+1:FW]);
          rd_cyc.push_back(cyc);
          if (pbrr_data[BW-1:FW+PG+2] != '0 || pbrr_data[FW-1:0] != '0) hdr_bad++;
        end
        if (pend.size() > max_out) max_out = pend.size();
        if (lrq_srdy && lrq_drdy) begin
          lrq_log.push_back(lrq_page);
          lnk_pend.push_back(lrq_page);
          lnk_wait = lnk_delay;
        end
        if (lrs_srdy && lrs_drdy) void'(lnk_pend.pop_front());
        if (ptx_srdy && ptx_drdy) ptx_log.push_back(ptx_data);
        if (drf_srdy && drf_drdy) drf_log.push_back(drf_page);
      end else prev_stall = 1'b0;
      @(posedge clk);
      #1;
      if (reset) begin
        pend.delete();
        lnk_pend.delete();
      end
      if (pbrs_hold > 0) pbrs_hold--;
      if (lnk_wait > 0) lnk_wait--;
      pbrs_srdy = pend.size() > 0 && pbrs_hold == 0;
      a = pbrs_srdy ? pend[0] : '0;
      pbrs_data = pbrs_srdy ? word(a[PG+1:2], a[1:0]) : '0;
      lrs_srdy = lnk_pend.size() > 0 && lnk_wait == 0;
      lrs_page = lrs_srdy ? nxt_tbl[lnk_pend[0]] : '0;
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    rd_log.delete();
    rd_cyc.delete();
    lrq_log.delete();
    ptx_log.delete();
    drf_log.delete();
    max_out = 0;
    hdr_bad = 0;
  endtask

  task automatic send(logic [PG-1:0] s, logic [PG-1:0] e);
    bit ok = 0;
    f2r_srdy = 1'b1;
    f2r_start = s;
    f2r_end = e;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      ok = f2r_drdy;
    end
    if (!ok) check("desc_accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    f2r_srdy = 1'b0;
  endtask

  task automatic wait_drf(int n);
    bit ok = 0;
    for (int t = 0; t < 400 && !ok; t++) begin
      @(negedge clk);
      ok = drf_log.size() >= n;
    end
    if (!ok) check("drf_wait_timeout", drf_log.size(), n);
    tick(8);
  endtask

  task automatic check_pkt(string tag, logic [PG-1:0] pgs [3], int np, int nptx);
    check({tag, "_nrd"}, rd_log.size(), 4 * np);
    for (int i = 0; i < 4 * np; i++)
      if (i < rd_log.size()) check({tag, "_rd_addr"}, rd_log[i], {pgs[i/4], 2'(i % 4)});
    check({tag, "_nptx"}, ptx_log.size(), nptx);
    for (int i = 0; i < nptx; i++)
      if (i < ptx_log.size()) check({tag, "_ptx_data"}, ptx_log[i], word(pgs[i/4], 2'(i % 4)));
    check({tag, "_ndrf"}, drf_log.size(), np);
    for (int i = 0; i < np; i++)
      if (i < drf_log.size()) check({tag, "_drf_page"}, drf_log[i], pgs[i]);
    check({tag, "_nlrq"}, lrq_log.size(), np - 1);
    for (int i = 0; i < np - 1; i++)
      if (i < lrq_log.size()) check({tag, "_lrq_page"}, lrq_log[i], pgs[i]);
  endtask

  initial begin
    bit ok;
    for (int i = 0; i < 16; i++) nxt_tbl[i] = '0;
    nxt_tbl[2] = 4'd7;
    nxt_tbl[7] = 4'd9;
    tick(2);
    check("rst_outputs", {f2r_drdy, lrq_srdy, lrs_drdy, pbrr_srdy, pbrs_drdy, ptx_srdy, drf_srdy}, 7'b0);
    reset = 1'b0;
    tick(1);
    check("post_rst_f2r_drdy", f2r_drdy, 1);
    check("post_rst_pbrs_drdy", pbrs_drdy, 1);
    check("post_rst_pbrr_srdy", pbrr_srdy, 0);

    // single page, EOP on line 1: lines 2..3 dropped, page still freed once
    clear_logs();
    eop_pg = 4'd5; eop_ln = 2'd1;
    send(4'd5, 4'd5);
    wait_drf(1);
    check_pkt("t1", '{4'd5, 4'd0, 4'd0}, 1, 2);
    check("t1_req_hdr", hdr_bad, 0);

    // three-page chain
    clear_logs();
    eop_pg = 4'd9; eop_ln = 2'd3;
    send(4'd2, 4'd9);
    wait_drf(3);
    check_pkt("t2", '{4'd2, 4'd7, 4'd9}, 3, 12);

    // read data held off: issue must stop at RD_DEPTH outstanding
    clear_logs();
    eop_pg = 4'd7; eop_ln = 2'd3;
    pbrs_hold = 20;
    send(4'd2, 4'd7);
    tick(10);
    check("t3_reads_while_held", rd_log.size(), RD);
    check("t3_outstanding", pend.size(), RD);
    wait_drf(2);
    check_pkt("t3", '{4'd2, 4'd7, 4'd0}, 2, 8);
    check("t3_max_outstanding", max_out, RD);

    // tx back-pressure mid-packet
    clear_logs();
    send(4'd2, 4'd7);
    tick(4);
    ptx_drdy = 1'b0;
    tick(10);
    check("t4_stalled_mid_pkt", ptx_log.size() > 0 && ptx_log.size() < 8, 1);
    ptx_drdy = 1'b1;
    wait_drf(2);
    check_pkt("t4", '{4'd2, 4'd7, 4'd0}, 2, 8);

    // slow link response: reads pause until the next page is known
    clear_logs();
    lnk_delay = 8;
    send(4'd2, 4'd7);
    wait_drf(2);
    lnk_delay = 1;
    check_pkt("t5", '{4'd2, 4'd7, 4'd0}, 2, 8);
    if (rd_cyc.size() >= 5) check("t5_link_gap", (rd_cyc[4] - rd_cyc[3]) >= 5, 1);
    else check("t5_rd_count", rd_cyc.size(), 8);

    // reset in the middle of the second page, then a clean packet
    clear_logs();
    eop_pg = 4'd9; eop_ln = 2'd3;
    send(4'd2, 4'd9);
    ok = 0;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk);
      ok = rd_log.size() >= 6;
    end
    if (!ok) check("t6_wait_timeout", rd_log.size(), 6);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("t6_async_rst_outputs", {f2r_drdy, lrq_srdy, lrs_drdy, pbrr_srdy, pbrs_drdy, ptx_srdy, drf_srdy}, 7'b0);
    tick(2);
    reset = 1'b0;
    tick(1);
    clear_logs();
    eop_pg = 4'd5; eop_ln = 2'd1;
    send(4'd5, 4'd5);
    wait_drf(1);
    check_pkt("t6", '{4'd5, 4'd0, 4'd0}, 1, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
